// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing generator.
// Holds the 640x480@60 default timing and the test-pattern mode encoding.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    GRID    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } pattern_mode_e;

  // Length of one axis (line or frame) in pixels or lines.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of the VGA timing generator: pixel enable and pattern
// select in, syncs/coordinates/pulses/colour out.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int H_W     = $clog2(axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP)),
  parameter int V_W     = $clog2(axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP)),
  parameter int COLOR_W = 1
) ();

  logic               ce;
  logic [1:0]         mode;
  logic               vga_h_sync;
  logic               vga_v_sync;
  logic               de;
  logic [H_W-1:0]     pix_x;
  logic [V_W-1:0]     pix_y;
  logic               frame_start;
  logic               line_start;
  logic [COLOR_W-1:0] R;
  logic [COLOR_W-1:0] G;
  logic [COLOR_W-1:0] B;

  modport master (
    input  ce, mode,
    output vga_h_sync, vga_v_sync, de, pix_x, pix_y,
           frame_start, line_start, R, G, B
  );

  modport slave (
    output ce, mode,
    input  vga_h_sync, vga_v_sync, de, pix_x, pix_y,
           frame_start, line_start, R, G, B
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter over ACTIVE+FP+SYNC+BP plus the
// active/sync phase decode of the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP,
  parameter int W      = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam int          TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] MAX    = W'(TOTAL - 1);
  localparam logic [31:0] ACT_END = 32'(ACTIVE);
  localparam logic [31:0] SYN_BEG = 32'(ACTIVE + FP);
  localparam logic [31:0] SYN_END = 32'(ACTIVE + FP + SYNC);

  logic [W-1:0] cnt_q, cnt_d;
  logic [31:0]  cnt32;

  // Next count: advance when enabled, wrap from the last count back to 0.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + W'(1);
    end
  end

  // Count register, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Phase decode is done in 32 bits so a sync ending exactly at TOTAL cannot overflow W.
  always_comb begin
    cnt32    = 32'(cnt_q);
    active_o = (cnt32 < ACT_END);
    sync_o   = (cnt32 >= SYN_BEG) && (cnt32 < SYN_END);
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters, registered syncs,
// display enable, coordinates and line/frame pulses, one cycle behind the
// counters. Optional test-pattern colour source is built only when the
// macro VGA_TEST_PATTERN_EN is defined; otherwise R/G/B are tied to 0.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam logic [H_W-1:0] H_MAX = H_W'(H_TOTAL - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           h_active, h_sync, v_active, v_sync;
  logic           v_en;

  // The vertical axis steps only on the enabled edge that wraps the line.
  assign v_en = vga.ce && (h_cnt == H_MAX);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(H_W)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (vga.ce),
    .cnt_o   (h_cnt),
    .active_o(h_active),
    .sync_o  (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(V_W)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (v_en),
    .cnt_o   (v_cnt),
    .active_o(v_active),
    .sync_o  (v_sync)
  );

  logic           hs_d, vs_d, de_d, fs_d, ls_d;
  logic           hs_q, vs_q, de_q, fs_q, ls_q;
  logic [H_W-1:0] x_q;
  logic [V_W-1:0] y_q;

  // Output values describing the pixel the counters currently point at.
  always_comb begin
    hs_d = h_sync ? HS_POL : ~HS_POL;
    vs_d = v_sync ? VS_POL : ~VS_POL;
    de_d = h_active && v_active;
    ls_d = (h_cnt == '0);
    fs_d = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output registers: level outputs hold while ce=0, pulses drop so they never repeat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      fs_q <= 1'b0;
      ls_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      fs_q <= vga.ce && fs_d;
      ls_q <= vga.ce && ls_d;
      if (vga.ce) begin
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
        x_q  <= h_cnt;
        y_q  <= v_cnt;
      end
    end
  end

  assign vga.vga_h_sync  = hs_q;
  assign vga.vga_v_sync  = vs_q;
  assign vga.de          = de_q;
  assign vga.pix_x       = x_q;
  assign vga.pix_y       = y_q;
  assign vga.frame_start = fs_q;
  assign vga.line_start  = ls_q;

`ifdef VGA_TEST_PATTERN_EN
  logic [COLOR_W-1:0] r_d, g_d, b_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [31:0]        x32, y32;
  logic [2:0]         bar;

  // Pattern colour for the current pixel; black outside the visible area.
  always_comb begin
    x32 = 32'(h_cnt);
    y32 = 32'(v_cnt);
    bar = 3'((x32 * 32'd8) / 32'(H_ACTIVE));
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (de_d) begin
      case (pattern_mode_e'(vga.mode))
        BARS: begin
          r_d = {COLOR_W{bar[2]}};
          g_d = {COLOR_W{bar[1]}};
          b_d = {COLOR_W{bar[0]}};
        end
        GRID: begin
          if ((x32[4:0] == 5'd0) || (y32[4:0] == 5'd0)) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
          end
        end
        CHECKER: begin
          if (x32[4] ^ y32[4]) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
          end
        end
        SOLID: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
        default: begin
          r_d = '0;
          g_d = '0;
          b_d = '0;
        end
      endcase
    end
  end

  // Colour registers share the timing of the sync/de registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else if (vga.ce) begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign vga.R = r_q;
  assign vga.G = g_q;
  assign vga.B = b_q;
`else
  assign vga.R = {COLOR_W{1'b0}};
  assign vga.G = {COLOR_W{1'b0}};
  assign vga.B = {COLOR_W{1'b0}};
`endif

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
- REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
- REQ-002 The block SHALL have parameters H_FP, H_SYNC and H_BP, defaults 16, 96 and 48, which are the horizontal front porch, sync and back porch in pixels.
- REQ-003 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
- REQ-004 The block SHALL have parameters V_FP, V_SYNC and V_BP, defaults 10, 2 and 33, which are the vertical front porch, sync and back porch in lines.
- REQ-005 The block SHALL have parameters HS_POL and VS_POL, default 0 for both, giving the active level of each sync.
- REQ-006 The block SHALL have parameter COLOR_W, default 1, the bits per colour channel.
- REQ-007 The block SHALL have port clk, input, 1 bit: the single clock.
- REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
- REQ-009 The block SHALL have port ce, input, 1 bit: pixel clock enable.
- REQ-010 The block SHALL have port mode, input, 2 bits: test pattern select.
- REQ-011 The block SHALL have ports vga_h_sync and vga_v_sync, outputs, 1 bit each: the sync outputs, already at their configured polarity.
- REQ-012 The block SHALL have port de, output, 1 bit: display enable, high during visible pixels.
- REQ-013 The block SHALL have ports pix_x and pix_y, outputs, with widths $clog2(H_TOTAL) and $clog2(V_TOTAL): the pixel coordinates.
- REQ-014 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse at pixel (0,0).
- REQ-015 The block SHALL have port line_start, output, 1 bit: a one-cycle pulse at x=0 of every line.
- REQ-016 The block SHALL have ports R, G and B, outputs, COLOR_W bits each: pixel colour.

Function
- REQ-017 Totals SHALL be H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP.
- REQ-018 Internal h_cnt SHALL advance by 1 on each clk edge with ce=1, and wrap from H_TOTAL-1 to 0.
- REQ-019 Internal v_cnt SHALL advance by 1 only when h_cnt wraps, and wrap from V_TOTAL-1 to 0 when both counters are at max at the same time.
- REQ-020 Each axis SHALL be decoded into the phases ACTIVE, FP, SYNC and BP in that order, with ACTIVE starting at count 0.
- REQ-021 Sync SHALL be active for counts in [ACTIVE+FP, ACTIVE+FP+SYNC) of its axis.
- REQ-022 de SHALL be 1 only when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- REQ-023 All outputs SHALL be registered and reflect the counter state with 1-cycle latency.
- REQ-024 pix_x and pix_y SHALL equal the counters, including during blanking.
- REQ-025 frame_start SHALL be 1 for exactly the cycle whose outputs describe pixel (0,0).
- REQ-026 line_start SHALL be 1 for exactly the cycles whose outputs describe x=0.
- REQ-027 With ce=0, the counters and all outputs SHALL hold, and pulses SHALL NOT repeat.
- REQ-028 A mode change SHALL take effect on the next enabled pixel, with no resync of timing.

Reset
- REQ-029 While rst_n=0, counters SHALL be 0, and syncs SHALL be at their inactive level (~HS_POL, ~VS_POL).
- REQ-030 While rst_n=0, de, frame_start, line_start, pix_x, pix_y, R, G and B SHALL be 0.
- REQ-031 The first ce=1 edge after rst_n rises SHALL emit pixel (0,0), with de=1, frame_start=1 and line_start=1.
- REQ-032 Reset asserted mid-frame SHALL immediately force the reset values, with no partial-line completion.

Configuration
- REQ-033 The block SHALL have macro VGA_TEST_PATTERN_EN.
- REQ-034 With VGA_TEST_PATTERN_EN defined, R/G/B SHALL follow mode when de=1:
  - 0: eight vertical colour bars, bar index = pix_x*8/H_ACTIVE, R=bit2, G=bit1, B=bit0.
  - 1: white grid lines where pix_x[4:0]==0 or pix_y[4:0]==0, black elsewhere.
  - 2: checkerboard, white when pix_x[4]^pix_y[4]=1.
  - 3: solid white.
  - White is all-ones per channel.
- REQ-035 With VGA_TEST_PATTERN_EN defined, R/G/B SHALL be 0 whenever de=0.
- REQ-036 Without VGA_TEST_PATTERN_EN, R/G/B SHALL be constant 0, mode SHALL be ignored, and no pattern logic SHALL be synthesised.

Structure
- REQ-037 Package vga_pkg SHALL hold the 640x480@60 default timing constants and the pattern-mode enumeration (BARS, GRID, CHECKER, SOLID).
- REQ-038 Sub-module vga_axis_counter SHALL be instantiated twice, once per axis; it holds the count, wrap and phase decode, with parameters ACTIVE, FP, SYNC and BP.

Verification
- REQ-039 Defaults, ce=1 -> vga_h_sync=0 exactly on output cycles x=656..751; line period 800 cycles; frame period 420000 cycles.
- REQ-040 Defaults -> vga_v_sync=0 on lines 490..491; de high for 640 cycles per line on lines 0..479 only; 307200 de cycles per frame.
- REQ-041 H=8/2/2/2, V=4/1/1/1, HS_POL=VS_POL=1 -> sync is high-active, line period 14, frame period 98, frame_start every 98 cycles.
- REQ-042 ce toggled 1-0 every cycle -> every period doubles and pulses stay one cycle wide.
- REQ-043 rst_n pulsed low at pixel (300,200) -> reset values appear at once; first ce edge after release -> frame_start=1 with pix_x=0 and pix_y=0.
- REQ-044 VGA_TEST_PATTERN_EN, mode=0, COLOR_W=1 -> pixel x=0 gives RGB 000, x=639 gives RGB 111, and x=80 gives RGB 001; blanking gives RGB 000.
